// File: rtl/symbol_stream_gen.sv
// Plays a latched word of NSYM base-4 symbols MSB-first on a[1:0], HOLD clocks per symbol.
// Optional macro SSG_REPEAT_EN: loop the latched word until stop is asserted.
module symbol_stream_gen #(
  parameter int unsigned NSYM = 9,
  parameter int unsigned HOLD = 2,
  parameter int unsigned IDXW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2*NSYM-1:0] word,
  input  logic              pause,
  input  logic              stop,
  output logic [1:0]        a,
  output logic              a_valid,
  output logic              busy,
  output logic              done,
  output logic [IDXW-1:0]   sym_idx
);

  localparam int unsigned W  = 2 * NSYM;
  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

`ifdef SSG_REPEAT_EN
  localparam bit RepeatEn = 1'b1;
`else
  localparam bit RepeatEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    word_q, word_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            done_q, done_d;
  logic            stop_hit;

  // Folds to constant 0 when looping is not built in.
  assign stop_hit = stop & RepeatEn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      word_q  <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          word_d  = word;
          hold_d  = '0;
          idx_d   = '0;
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (stop_hit) begin
          hold_d  = '0;
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (!pause) begin
          if (hold_q == HW'(HOLD - 1)) begin
            hold_d = '0;
            if (idx_q == IDXW'(NSYM - 1)) begin
              // End of pass: loop back to symbol 0 or retire through StDone.
              idx_d   = '0;
              done_d  = 1'b1;
              state_d = RepeatEn ? StPlay : StDone;
            end else begin
              idx_d = idx_q + IDXW'(1);
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a = 2'b00;
    if (state_q == StPlay) begin
      a = word_q[W - 1 - 2 * int'(idx_q) -: 2];
    end
  end

  assign a_valid = (state_q == StPlay);
  assign busy    = (state_q == StPlay);
  assign done    = done_q;
  assign sym_idx = idx_q;

endmodule

// File: tb/tb_symbol_stream_gen.sv
// Scoreboard bench for symbol_stream_gen: stimulus pushes expected symbols and done
// cycles, a negedge monitor pops and compares them as the DUT presents output.
module tb_symbol_stream_gen;

  localparam int unsigned NSYM = 9;
  localparam int unsigned IDXW = 4;
`ifdef SSG_REPEAT_EN
  localparam int unsigned HOLD = 1;
`else
  localparam int unsigned HOLD = 2;
`endif

  logic              clk;
  logic              reset;
  logic              start;
  logic [2*NSYM-1:0] word;
  logic              pause;
  logic              stop;
  logic [1:0]        a;
  logic              a_valid;
  logic              busy;
  logic              done;
  logic [IDXW-1:0]   sym_idx;

  symbol_stream_gen #(.NSYM(NSYM), .HOLD(HOLD), .IDXW(IDXW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .word   (word),
    .pause  (pause),
    .stop   (stop),
    .a      (a),
    .a_valid(a_valid),
    .busy   (busy),
    .done   (done),
    .sym_idx(sym_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]      a;
    logic [IDXW-1:0] idx;
  } exp_t;

  exp_t sym_q[$];
  int   done_q[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;

  // 18'h16977 = 92535 = 01_01_10_10_01_01_11_01_11
  logic [1:0] syms [NSYM] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd1, 2'd3};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    int   dc;
    if (mon_en) begin
      checks++;
      if (a_valid) begin
        if (sym_q.size() == 0) begin
          errors++;
          $display("FAIL sym_unexpected: a=%0d idx=%0d at cyc %0d, none expected", a, sym_idx, cyc);
        end else begin
          e = sym_q.pop_front();
          if (a !== e.a || sym_idx !== e.idx || busy !== 1'b1) begin
            errors++;
            $display("FAIL sym: cyc %0d got a=%0d idx=%0d busy=%0d, expected a=%0d idx=%0d busy=1",
                     cyc, a, sym_idx, busy, e.a, e.idx);
          end
        end
      end else if (a !== 2'd0 || busy !== 1'b0 || sym_idx !== '0) begin
        errors++;
        $display("FAIL idle: cyc %0d got a=%0d busy=%0d idx=%0d, expected 0/0/0",
                 cyc, a, busy, sym_idx);
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: done=1 at cyc %0d, none expected", cyc);
        end else begin
          dc = done_q.pop_front();
          if (dc != cyc) begin
            errors++;
            $display("FAIL done_cycle: done at cyc %0d, expected cyc %0d", cyc, dc);
          end
        end
      end
    end
  end

  // Pushes one pass; symbol at pause_idx gets extra pause_len cycles.
  task automatic push_pass(input int pause_idx, input int pause_len);
    exp_t e;
    for (int i = 0; i < int'(NSYM); i++) begin
      for (int k = 0; k < int'(HOLD) + ((i == pause_idx) ? pause_len : 0); k++) begin
        e.a   = syms[i];
        e.idx = IDXW'(i);
        sym_q.push_back(e);
      end
    end
  endtask

  // Returns at the negedge right after the accepting edge (cyc == e0).
  task automatic start_pass(input logic [2*NSYM-1:0] w, input int pause_idx,
                            input int pause_len, input int done_off, output int e0);
    @(negedge clk);
    start = 1'b1;
    word  = w;
    e0    = cyc + 1;
    push_pass(pause_idx, pause_len);
    done_q.push_back(e0 + done_off);
    @(negedge clk);
    start = 1'b0;
    word  = 18'h3ffff;
  endtask

  int e0;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    word  = '0;
    pause = 1'b0;
    stop  = 1'b0;
    #1;
    chk("rst_a", int'(a), 0);
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idx", int'(sym_idx), 0);
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-playback, applied away from any clock edge.
    start_pass(18'h16977, -1, 0, NSYM * HOLD, e0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_a", int'(a), 0);
    chk("mid_rst_valid", int'(a_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_idx", int'(sym_idx), 0);
    sym_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

`ifdef SSG_REPEAT_EN
    // Two full passes, third pass stopped after two symbols.
    start_pass(18'h16977, -1, 0, NSYM, e0);
    push_pass(-1, 0);
    done_q.push_back(e0 + 18);
    begin
      exp_t e;
      for (int i = 0; i < 2; i++) begin
        e.a   = syms[i];
        e.idx = IDXW'(i);
        sym_q.push_back(e);
      end
    end
    done_q.push_back(e0 + 20);
    repeat (19) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
`else
    // Plain pass; stop must be ignored in this build.
    start_pass(18'h16977, -1, 0, 18, e0);
    repeat (3) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (14) @(negedge clk);

    // Back-to-back start; pause 3 clocks on the first cycle of symbol 4.
    start_pass(18'h16977, 4, 3, 21, e0);
    repeat (8) @(negedge clk);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    pause = 1'b0;
    repeat (10) @(negedge clk);

    // start with word=0 during playback must be ignored.
    start_pass(18'h16977, -1, 0, 18, e0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    word  = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);

    // pause in idle has no effect.
    pause = 1'b1;
    repeat (3) @(negedge clk);
    pause = 1'b0;
`endif

    repeat (3) @(negedge clk);
    chk("leftover_syms", sym_q.size(), 0);
    chk("leftover_done", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
